serial_left_shifter: RTL and testbench
======================================

Name: serial_left_shifter

Overview:
- Multi-cycle logical left shifter for the processor's SLL path.
- The opposite direction of the existing 1-bit arithmetic right-shift stage.
- Shifts a 32-bit operand left by 0..31, one bit per clock, and zero-fills the LSB.
- Start/done handshake lets the execute stage stall on it. Also reports whether any 1 bit was shifted out of the MSB.

Parameters:
- WIDTH, 32, operand/result width in bits
- SHAMT_W, 5, shift-amount width; WIDTH == 2**SHAMT_W

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- data_in  input  WIDTH  operand, captured on accepted start
- shamt  input  SHAMT_W  shift amount, captured on accepted start
- ready  output  1  high only in IDLE; start is accepted iff start&ready
- busy  output  1  high in SHIFT and DONE states
- done  output  1  one-cycle pulse; result/lost valid in that cycle
- result  output  WIDTH  shifted operand; registered, held until next accepted start
- lost  output  1  OR of every bit shifted out past bit WIDTH-1; held with result

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`, evaluated at the rising edge and overriding all other inputs.
- Reset values:
  - state = IDLE
  - ready = 1, busy = 0, done = 0
  - result = 0, lost = 0
  - internal count = 0
- States:
  - IDLE: ready=1.
    - On start: reg <= data_in, cnt <= shamt, lost_acc <= 0.
    - Next state is SHIFT if shamt != 0, otherwise DONE.
  - SHIFT: each cycle, reg <= {reg[WIDTH-2:0],1'b0}, lost_acc <= lost_acc | reg[WIDTH-1], cnt <= cnt-1.
    - When cnt == 1 (the last step), go to DONE.
  - DONE: done=1 for exactly this cycle; result = reg, lost = lost_acc. Next state is always IDLE.
- Latency: with start accepted at edge 0, done is high during the cycle after edge shamt.
  - shamt=0 gives done one cycle after the start cycle.
  - shamt=31 gives done 32 cycles after the start cycle.
- Throughput: one operation per shamt+2 cycles. A new start may be accepted in the IDLE cycle that immediately follows DONE.
- result and lost update only when DONE is entered, and are stable at all other times, including while a new operation is in SHIFT.
- Input capture:
  - start while busy=1 (SHIFT or DONE) is ignored, with no queueing.
  - data_in and shamt are don't-care except in the accept cycle; changes during SHIFT have no effect.
- Arithmetic: logical shift only; the vacated LSBs are always 0. No sign extension in either direction. Arithmetic right shift stays in the right-shift path.
- Boundaries:
  - shamt=0 passes the operand through unchanged, with lost=0.
  - Any 1 in data_in[WIDTH-1:WIDTH-shamt] sets lost.
- Reset mid-operation (any state) aborts the operation:
  - state IDLE, result=0, lost=0.
  - No done pulse for the aborted operation.
- Reset and start in the same cycle: reset wins and the start is dropped.

Optional Feature:
- Macro: SHIFT_STEP4_EN
- Defined: in SHIFT, if cnt >= 4 the block shifts 4 bits in one cycle: reg <= reg<<4, cnt -= 4, lost_acc |= OR(reg[WIDTH-1:WIDTH-4]). Otherwise it shifts 1 bit as in the base design.
  - DONE is entered when cnt reaches 0.
  - Latency = floor(shamt/4) + (shamt mod 4) shift cycles, then DONE.
  - result and lost are bit-identical to the base design.
- Undefined: strictly 1 bit per cycle, latency as in Behaviour.

Test Plan:
- Zero shift: reset, then start with data_in=0xDEADBEEF, shamt=0 → done one cycle after start; result=0xDEADBEEF, lost=0.
- Basic shift: data_in=0x00000001, shamt=4 → done 5 cycles after start; result=0x00000010, lost=0; ready low until done+1.
- Maximum shift: data_in=0xFFFFFFFF, shamt=31 → result=0x80000000, lost=1.
  - Base design: done at cycle 32.
  - With SHIFT_STEP4_EN: done at cycle 11.
- Ignored start: data_in=0x00000003, shamt=8 → result=0x00000300. Pulse start with 0x12345678/shamt=1 during SHIFT and again during DONE → both ignored; exactly one done pulse.
- Reset abort: start with data_in=0x80000001, shamt=20. Assert reset at cycle 10 → next cycle ready=1, result=0, lost=0, and no done pulse appears.
- Back-to-back and hold: start op A (0x0000000F, shamt=28 → 0xF0000000, lost=0). Start op B (0xF0000000, shamt=1) in the IDLE cycle right after A's done → B is accepted. result holds 0xF0000000 throughout B's SHIFT, then becomes 0xE0000000 with lost=1.

Source files
------------

// File: rtl/serial_left_shifter.sv
// serial_left_shifter: multi-cycle logical left shifter for the SLL path.
// Shifts a WIDTH-bit operand left by 0..2**SHAMT_W-1 using a start/done
// handshake, zero-filling the LSBs and flagging any 1 shifted past the MSB.
// Optional build macro: SHIFT_STEP4_EN (shift 4 bits per cycle while at
// least 4 remain; result and lost are identical to the 1-bit build).
module serial_left_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               lost
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nx;
  logic [WIDTH-1:0]   sreg;
  logic [WIDTH-1:0]   sreg_nx;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] cnt_nx;
  logic               lost_acc;
  logic               lost_nx;

  // Next-state, shift-datapath and lost-bit accumulation.
  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    lost_nx  = lost_acc;
    case (state)
      IDLE: begin
        if (start) begin
          sreg_nx  = data_in;
          cnt_nx   = shamt;
          lost_nx  = 1'b0;
          state_nx = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
`ifdef SHIFT_STEP4_EN
        if (cnt >= SHAMT_W'(4)) begin
          sreg_nx = {sreg[WIDTH-5:0], 4'b0000};
          lost_nx = lost_acc | (|sreg[WIDTH-1:WIDTH-4]);
          cnt_nx  = cnt - SHAMT_W'(4);
        end else begin
          sreg_nx = {sreg[WIDTH-2:0], 1'b0};
          lost_nx = lost_acc | sreg[WIDTH-1];
          cnt_nx  = cnt - SHAMT_W'(1);
        end
`else
        sreg_nx = {sreg[WIDTH-2:0], 1'b0};
        lost_nx = lost_acc | sreg[WIDTH-1];
        cnt_nx  = cnt - SHAMT_W'(1);
`endif
        // Finishing on a zero remaining count covers both the cnt==1
        // single-step exit and the 4-step exit.
        if (cnt_nx == '0) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State registers; result/lost load only on the transition into DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      lost_acc <= 1'b0;
      result   <= '0;
      lost     <= 1'b0;
    end else begin
      state    <= state_nx;
      sreg     <= sreg_nx;
      cnt      <= cnt_nx;
      lost_acc <= lost_nx;
      if ((state_nx == DONE) && (state != DONE)) begin
        result <= sreg_nx;
        lost   <= lost_nx;
      end
    end
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    ready = (state == IDLE);
    busy  = (state == SHIFT) || (state == DONE);
    done  = (state == DONE);
  end

endmodule

// File: tb/tb_serial_left_shifter.sv
// tb_serial_left_shifter: table vectors, directed corner sequences and
// random operations checked against an arithmetic reference model.
module tb_serial_left_shifter;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        lost;

  int checks = 0;
  int errors = 0;
  logic [31:0] hold_res  = '0;
  logic        hold_lost = 1'b0;

  serial_left_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .shamt   (shamt),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .lost    (lost)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    int          s;
    logic [31:0] res;
    logic        lst;
  } vec_t;

  function automatic logic [31:0] m_res(input logic [31:0] d, input int s);
    logic [63:0] w;
    w = {32'b0, d} << s;
    return w[31:0];
  endfunction

  function automatic logic m_lost(input logic [31:0] d, input int s);
    logic [63:0] w;
    w = {32'b0, d} << s;
    return |w[63:32];
  endfunction

  // Cycles from the accept cycle to the done cycle.
  function automatic int m_lat(input int s);
`ifdef SHIFT_STEP4_EN
    return (s / 4) + (s % 4) + 1;
`else
    return s + 1;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one operation and wait for done; ends on the done cycle's negedge.
  task automatic do_op(input logic [31:0] d, input int s,
                       input logic [31:0] er, input logic el);
    int n;
    @(negedge clock);
    chk("ready_before_start", ready, 1);
    data_in = d;
    shamt   = 5'(s);
    start   = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    data_in = $urandom;
    shamt   = 5'($urandom);
    n = 1;
    while (!done && n < 200) begin
      chk("busy_in_shift", busy, 1);
      chk("result_hold", result, hold_res);
      chk("lost_hold", lost, hold_lost);
      @(negedge clock);
      n++;
    end
    chk("latency", n, m_lat(s));
    chk("result", result, er);
    chk("lost", lost, el);
    chk("busy_in_done", busy, 1);
    hold_res  = er;
    hold_lost = el;
  endtask

  task automatic after_done;
    @(negedge clock);
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", ready, 1);
  endtask

  initial begin
    vec_t tbl[7];
    int n;
    int dones;
    int abort_cyc;
    logic [31:0] rd;
    int rs;

    tbl[0] = '{32'hDEADBEEF, 0,  32'hDEADBEEF, 1'b0};
    tbl[1] = '{32'h00000001, 4,  32'h00000010, 1'b0};
    tbl[2] = '{32'hFFFFFFFF, 31, 32'h80000000, 1'b1};
    tbl[3] = '{32'h80000000, 1,  32'h00000000, 1'b1};
    tbl[4] = '{32'h12345678, 16, 32'h56780000, 1'b1};
    tbl[5] = '{32'h0000F000, 16, 32'hF0000000, 1'b0};
    tbl[6] = '{32'h00010000, 16, 32'h00000000, 1'b1};

    reset = 1'b1; start = 1'b0; data_in = '0; shamt = '0;
    repeat (3) @(negedge clock);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_lost", lost, 0);
    reset = 1'b0;

    // Table vectors
    foreach (tbl[i]) begin
      do_op(tbl[i].d, tbl[i].s, tbl[i].res, tbl[i].lst);
      after_done();
    end

    // Starts during SHIFT and during DONE are ignored
    @(negedge clock);
    data_in = 32'h3; shamt = 5'd8; start = 1'b1;
    @(negedge clock);
    start = 1'b0; n = 1;
    @(negedge clock);
    n++;
    chk("ign_busy_c2", busy, 1);
    data_in = 32'h12345678; shamt = 5'd1; start = 1'b1;
    @(negedge clock);
    n++;
    start = 1'b0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("ign_latency", n, m_lat(8));
    chk("ign_result", result, 32'h00000300);
    chk("ign_lost", lost, 0);
    data_in = 32'h12345678; shamt = 5'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("ign_ready_idle", ready, 1);
    dones = 0;
    repeat (20) begin
      @(negedge clock);
      if (done) dones++;
    end
    chk("ign_extra_dones", dones, 0);
    chk("ign_result_hold", result, 32'h00000300);
    hold_res = 32'h300; hold_lost = 1'b0;

    // Reset aborts an operation in SHIFT
`ifdef SHIFT_STEP4_EN
    abort_cyc = 3;
`else
    abort_cyc = 10;
`endif
    @(negedge clock);
    data_in = 32'h80000001; shamt = 5'd20; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    dones = 0;
    for (int c = 1; c < abort_cyc; c++) begin
      if (done) dones++;
      @(negedge clock);
    end
    chk("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_lost", lost, 0);
    repeat (40) begin
      @(negedge clock);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    hold_res = '0; hold_lost = 1'b0;

    // Reset and start together: start dropped
    @(negedge clock);
    data_in = 32'hFFFFFFFF; shamt = 5'd3; start = 1'b1; reset = 1'b1;
    @(negedge clock);
    start = 1'b0; reset = 1'b0;
    chk("rststart_ready", ready, 1);
    chk("rststart_busy", busy, 0);
    @(negedge clock);
    chk("rststart_done", done, 0);

    // Back-to-back with result hold through the second op's SHIFT
    do_op(32'h0000000F, 28, 32'hF0000000, 1'b0);
    do_op(32'hF0000000, 1, 32'hE0000000, 1'b1);
    after_done();

    // Random operations against the arithmetic model
    for (int k = 0; k < 30; k++) begin
      rd = $urandom;
      rs = $urandom_range(31, 0);
      if (k % 5 == 0) rd = 32'hFFFFFFFF >> $urandom_range(31, 0);
      do_op(rd, rs, m_res(rd, rs), m_lost(rd, rs));
      after_done();
      repeat ($urandom_range(2, 0)) @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
